seq_event_logger: RTL and testbench

// - Downstream consumer of the seq_circuit Moore output Y. Detects each high run of Y.
// - Each run produces one event record: start timestamp plus saturating run length.
// - Records are buffered in a small FIFO and presented on a valid/ready stream to the monitor/host side.
// - A sticky flag reports records dropped because the FIFO was full.

---
 rtl/seq_log_pkg.sv | 19 +
 rtl/seq_log_fifo.sv | 62 ++++++
 rtl/seq_event_logger.sv | 97 +++++++++
 tb/tb_seq_event_logger.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_log_pkg.sv
// Shared types, default sizes and helpers for the Y-run event logger.
`timescale 1ns/1ps
package seq_log_pkg;

  localparam int unsigned TS_W_DEF    = 8;
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned DEPTH_DEF   = 4;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [LEN_W_DEF-1:0] len;
  } evt_t;

  // Increment that sticks at max_len instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned len, input int unsigned max_len);
    return (len >= max_len) ? max_len : len + 1;
  endfunction

endpackage

// File: rtl/seq_log_fifo.sv
// First-word-fall-through FIFO; a push is accepted when full only if a pop happens on the same edge.
`timescale 1ns/1ps
module seq_log_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    if (!o_empty) o_rdata = r_mem[r_rptr];
  end

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CntW'(DEPTH));

endmodule

// File: rtl/seq_event_logger.sv
// Turns each high run of Y into a {start timestamp, saturated length} record on a valid/ready stream.
`timescale 1ns/1ps
module seq_event_logger
  import seq_log_pkg::*;
#(
  parameter int unsigned TS_W  = TS_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Y,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [TS_W-1:0]  evt_ts,
  output logic [LEN_W-1:0] evt_len,
  output logic             overflow
);

  localparam int unsigned MaxLen = (1 << LEN_W) - 1;
  localparam int unsigned RecW   = TS_W + LEN_W;

  logic [TS_W-1:0]  r_ts;
  logic             r_y_d;
  logic [LEN_W-1:0] r_run_len;
  logic [TS_W-1:0]  r_start_ts;
  logic             r_overflow;

  logic             w_rise;
  logic             w_cont;
  logic             w_fall;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [LEN_W-1:0] w_len_inc;
  logic [RecW-1:0]  w_rec;
  logic [RecW-1:0]  w_head;

  assign w_rise    = Y & ~r_y_d;
  assign w_cont    = Y & r_y_d;
  assign w_fall    = ~Y & r_y_d;
  assign w_pop     = evt_valid & evt_ready;
  assign w_drop    = w_fall & w_full & ~w_pop;
  assign w_len_inc = LEN_W'(sat_inc(32'(r_run_len), MaxLen));
  assign w_rec     = {r_start_ts, r_run_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_y_d      <= 1'b0;
      r_run_len  <= '0;
      r_start_ts <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts  <= r_ts + TS_W'(1);
      r_y_d <= Y;
      if (w_rise) begin
        r_start_ts <= r_ts;
        r_run_len  <= LEN_W'(1);
      end else if (w_cont) begin
        r_run_len <= w_len_inc;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  seq_log_fifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fall),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    evt_valid         = ~w_empty;
    {evt_ts, evt_len} = w_head;
    overflow          = r_overflow;
  end

  a_ovf_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    (r_overflow && !clr_ovf) |=> r_overflow);

endmodule

// File: tb/tb_seq_event_logger.sv
// Bench for seq_event_logger: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_seq_event_logger;
  import seq_log_pkg::*;

  localparam int unsigned TS_W  = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXL  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Y = 1'b0;
  logic             evt_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             evt_valid;
  logic [TS_W-1:0]  evt_ts;
  logic [LEN_W-1:0] evt_len;
  logic             overflow;

  always #5 clk = ~clk;

  seq_event_logger #(
    .TS_W  (TS_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Y         (Y),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .evt_len   (evt_len),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: records as a queue, the run measured as an unbounded count.
  int   m_ts;
  bit   m_yd;
  int   m_start;
  int   m_n;
  bit   m_ovf;
  evt_t m_q[$];

  task automatic m_reset();
    m_ts = 0; m_yd = 1'b0; m_start = 0; m_n = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Drive one clock with the given inputs and advance the model; returns at edge+1.
  task automatic cycle(input logic y, input logic rdy, input logic clr);
    bit   drop;
    evt_t rec;
    drop = 1'b0;
    Y = y; evt_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (y && !m_yd) begin
      m_start = m_ts;
      m_n     = 1;
    end else if (y && m_yd) begin
      m_n++;
    end
    if (!y && m_yd) begin
      rec.ts  = m_start[7:0];
      rec.len = 4'((m_n > MAXL) ? MAXL : m_n);
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_yd = y;
    m_ts = (m_ts + 1) % 256;
    #1;
  endtask

  task automatic apply_reset(input logic y_hold);
    rst_n = 1'b0; Y = y_hold; evt_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_checks++;
    if (evt_valid !== 1'b0 || evt_ts !== 8'd0 || evt_len !== 4'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b ts=%0d len=%0d ovf=%b expected 0/0/0/0",
               evt_valid, evt_ts, evt_len, overflow);
    end
  endtask

  task automatic test_single_run();
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: got %b expected 0", evt_valid);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd5 || evt_len !== 4'd3 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_record: got v=%b ts=%0d len=%0d ovf=%b expected 1/5/3/0",
               evt_valid, evt_ts, evt_len, overflow);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0 || evt_ts !== 8'd0) begin
      n_fail++;
      $display("FAIL single_one_cycle: got v=%b ts=%0d expected 0/0", evt_valid, evt_ts);
    end
  endtask

  task automatic test_saturate();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd10 || evt_len !== 4'd15) begin
      n_fail++;
      $display("FAIL saturate: got v=%b ts=%0d len=%0d expected 1/10/15",
               evt_valid, evt_ts, evt_len);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd3 || evt_len !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b ts=%0d len=%0d expected 1/3/1", evt_valid, evt_ts, evt_len);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd5 || evt_len !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b ts=%0d len=%0d expected 1/5/1", evt_valid, evt_ts, evt_len);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: got v=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (overflow !== 1'b1 || evt_ts !== 8'd0) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b head_ts=%0d expected 1/0", overflow, evt_ts);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ts !== 8'(2 * k) || evt_len !== 4'd1 || overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b ts=%0d len=%0d ovf=%b expected 1/%0d/1/1",
                 k, evt_valid, evt_ts, evt_len, overflow, 2 * k);
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got v=%b expected 0", evt_valid);
    end
    cycle(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop_push();
    int pops;
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b0 || evt_valid !== 1'b1 || evt_ts !== 8'd2) begin
      n_fail++;
      $display("FAIL full_popush: got ovf=%b v=%b ts=%0d expected 0/1/2", overflow, evt_valid, evt_ts);
    end
    pops = 0;
    while (evt_valid === 1'b1 && pops < 10) begin
      n_checks++;
      if (evt_ts !== 8'(2 + 2 * pops)) begin
        n_fail++;
        $display("FAIL full_order%0d: got ts=%0d expected %0d", pops, evt_ts, 2 + 2 * pops);
      end
      cycle(1'b0, 1'b1, 1'b0);
      pops++;
    end
    n_checks++;
    if (pops != 4) begin
      n_fail++;
      $display("FAIL full_occupancy: got %0d records expected 4", pops);
    end
  endtask

  task automatic test_wrap_reset();
    apply_reset(1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd255 || evt_len !== 4'd2) begin
      n_fail++;
      $display("FAIL wrap_record: got v=%b ts=%0d len=%0d expected 1/255/2", evt_valid, evt_ts, evt_len);
    end
    cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_ts !== 8'd0 || evt_len !== 4'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b ts=%0d len=%0d ovf=%b expected 0/0/0/0",
               evt_valid, evt_ts, evt_len, overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_record: got v=%b expected 0", evt_valid);
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== 8'd0 || evt_len !== 4'd1) begin
      n_fail++;
      $display("FAIL ts_restart: got v=%b ts=%0d len=%0d expected 1/0/1", evt_valid, evt_ts, evt_len);
    end
  endtask

  task automatic test_random();
    logic    y;
    logic    rdy;
    logic    clr;
    logic    exp_v;
    evt_t    exp_h;
    apply_reset(1'b0);
    y = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (y) y = ($urandom_range(11) == 0) ? 1'b0 : 1'b1;
      else   y = ($urandom_range(2) == 0) ? 1'b1 : 1'b0;
      if (((i / 500) % 2) == 1) rdy = ($urandom_range(7) == 0);
      else                      rdy = ($urandom_range(3) != 0);
      clr = ($urandom_range(31) == 0);
      cycle(y, rdy, clr);
      exp_v = (m_q.size() > 0);
      exp_h = exp_v ? m_q[0] : '0;
      n_checks++;
      if (evt_valid !== exp_v || evt_ts !== exp_h.ts || evt_len !== exp_h.len ||
          overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got v=%b ts=%0d len=%0d ovf=%b expected v=%b ts=%0d len=%0d ovf=%b",
                 i, evt_valid, evt_ts, evt_len, overflow, exp_v, exp_h.ts, exp_h.len, m_ovf);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_run();
    test_saturate();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
